// File: rtl/float_pkg.sv
// Shared widths, constants and FSM encoding for the 1.5 - x single-precision subtractor.
package float_pkg;

  localparam int C_SIGN_W = 1;
  localparam int C_EXP_W  = 8;
  localparam int C_MANT_W = 23;
  localparam int C_W      = C_SIGN_W + C_EXP_W + C_MANT_W;
  localparam int C_SIG_W  = C_MANT_W + 1;   // significand including hidden bit
  localparam int C_EXT_W  = C_SIG_W + 3;    // significand + guard, round, sticky

  localparam logic [C_EXP_W-1:0] C_BIAS    = 8'd127;
  localparam logic [C_EXP_W-1:0] C_EXP_MAX = 8'hFF;
  localparam logic [C_W-1:0]     C_ONE_P5  = 32'h3FC0_0000;
  localparam logic [C_W-1:0]     C_QNAN    = 32'h7FC0_0000;

  typedef enum logic [2:0] {
    IDLE,
    ALIGN,
    ADD,
    NORM,
    ROUND,
    DONE
  } state_t;

endpackage

// File: rtl/float_lzc.sv
// Combinational leading-zero counter over the 27-bit extended significand (27 when all zero).
module float_lzc
  import float_pkg::*;
(
  input  logic [C_EXT_W-1:0] din,
  output logic [4:0]         count
);

  // NOTE: every variable written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    count = 5'd27;
    // Scanning upward lets the highest set bit win.
    for (int i = 0; i < C_EXT_W; i++) begin
      if (din[i]) count = 5'(C_EXT_W - 1 - i);
    end
  end

endmodule

// File: rtl/float_sub_1d5.sv
// Multi-cycle float_out = 1.5 - float_in (RNE), fixed 4-cycle latency.
// Define FLOAT_SUB_DENORM_EN for gradual underflow; otherwise subnormals flush to zero.
module float_sub_1d5
  import float_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [C_W-1:0] float_in,
  output logic [C_W-1:0] float_out,
  output logic           ready
);

  state_t state_q, state_d;
  logic   capture;

  logic [C_W-1:0]     x_q;
  logic               special_q;
  logic [C_W-1:0]     special_val_q;
  logic               eff_sub_q;
  logic               big_sign_q;
  logic [C_EXP_W-1:0] big_exp_q;
  logic [C_EXT_W-1:0] big_sig_q;
  logic [C_EXT_W-1:0] small_sig_q;
  logic [C_EXT_W:0]   sum_q;
  logic               res_sign_q;
  logic signed [9:0]  res_exp_q;
  logic [C_EXT_W-1:0] norm_sig_q;
  logic signed [9:0]  norm_exp_q;

  assign capture = start && (state_q == IDLE || state_q == DONE);
  assign ready   = (state_q == DONE);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (start) state_d = ALIGN;
      ALIGN:      state_d = ADD;
      ADD:        state_d = NORM;
      NORM:       state_d = ROUND;
      ROUND:      state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  // ALIGN: decode -x, order the operands by magnitude and align the smaller one.
  logic               x_sign;
  logic [C_EXP_W-1:0] x_exp;
  logic [C_MANT_W-1:0] x_mant;
  logic               x_is_nan, x_is_inf;
  logic [C_EXP_W-1:0] a_exp, b_exp, shift_amt;
  logic [C_SIG_W-1:0] a_sig, b_sig, small_raw;
  logic               b_bigger;
  logic [49:0]        shifted;
  logic [C_EXT_W-1:0] small_aligned;

  assign {x_sign, x_exp, x_mant} = x_q;
  assign x_is_nan = (x_exp == C_EXP_MAX) && (x_mant != '0);
  assign x_is_inf = (x_exp == C_EXP_MAX) && (x_mant == '0);

  always_comb begin
    a_exp = C_BIAS;
    a_sig = {1'b1, C_ONE_P5[C_MANT_W-1:0]};
`ifdef FLOAT_SUB_DENORM_EN
    b_exp = (x_exp == '0) ? 8'd1 : x_exp;
    b_sig = {x_exp != '0, x_mant};
`else
    b_exp = x_exp;
    b_sig = (x_exp == '0) ? '0 : {1'b1, x_mant};
`endif
    b_bigger  = {b_exp, b_sig} > {a_exp, a_sig};
    shift_amt = b_bigger ? (b_exp - a_exp) : (a_exp - b_exp);
    small_raw = b_bigger ? a_sig : b_sig;
    shifted   = {small_raw, 26'd0} >> shift_amt;
    if (shift_amt >= 8'd26) small_aligned = {26'd0, |small_raw};
    else                    small_aligned = {shifted[49:24], |shifted[23:0]};
  end

  // NORM: carry shifts right by one; otherwise shift left by the leading-zero count.
  logic [4:0]         lz;
  logic signed [9:0]  shift_s;
  logic [C_EXT_W-1:0] norm_sig_d;
  logic signed [9:0]  norm_exp_d;

  float_lzc u_lzc (
    .din   (sum_q[C_EXT_W-1:0]),
    .count (lz)
  );

  always_comb begin
    shift_s = $signed({5'd0, lz});
`ifdef FLOAT_SUB_DENORM_EN
    // Stop at exponent 1 so the result becomes subnormal instead of underflowing.
    if (shift_s > res_exp_q - 10'sd1) shift_s = res_exp_q - 10'sd1;
`endif
    if (sum_q[C_EXT_W]) begin
      norm_sig_d = {sum_q[C_EXT_W:2], |sum_q[1:0]};
      norm_exp_d = res_exp_q + 10'sd1;
    end else begin
      norm_sig_d = sum_q[C_EXT_W-1:0] << shift_s[4:0];
      norm_exp_d = res_exp_q - shift_s;
    end
  end

  // ROUND: round-to-nearest-even, then pack with zero/overflow/underflow handling.
  logic               round_up, underflow;
  logic [C_SIG_W:0]   sig_inc;
  logic [C_SIG_W-1:0] rnd_sig;
  logic signed [9:0]  rnd_exp;
  logic [C_EXP_W-1:0] exp_field;
  logic [C_W-1:0]     result_d;

  always_comb begin
    round_up = norm_sig_q[2] & (norm_sig_q[3] | norm_sig_q[1] | norm_sig_q[0]);
    sig_inc  = {1'b0, norm_sig_q[C_EXT_W-1:3]} + {{C_SIG_W{1'b0}}, round_up};
    if (sig_inc[C_SIG_W]) begin
      rnd_sig = sig_inc[C_SIG_W:1];
      rnd_exp = norm_exp_q + 10'sd1;
    end else begin
      rnd_sig = sig_inc[C_SIG_W-1:0];
      rnd_exp = norm_exp_q;
    end
    exp_field = rnd_sig[C_SIG_W-1] ? rnd_exp[7:0] : 8'd0;
`ifdef FLOAT_SUB_DENORM_EN
    underflow = 1'b0;
`else
    underflow = (rnd_exp <= 10'sd0) || !rnd_sig[C_SIG_W-1];
`endif
    if (special_q)                   result_d = special_val_q;
    else if (norm_sig_q == '0)       result_d = '0;
    else if (rnd_exp >= 10'sd255)    result_d = {res_sign_q, C_EXP_MAX, {C_MANT_W{1'b0}}};
    else if (underflow)              result_d = '0;
    else                             result_d = {res_sign_q, exp_field, rnd_sig[C_MANT_W-1:0]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q           <= '0;
      special_q     <= 1'b0;
      special_val_q <= '0;
      eff_sub_q     <= 1'b0;
      big_sign_q    <= 1'b0;
      big_exp_q     <= '0;
      big_sig_q     <= '0;
      small_sig_q   <= '0;
      sum_q         <= '0;
      res_sign_q    <= 1'b0;
      res_exp_q     <= '0;
      norm_sig_q    <= '0;
      norm_exp_q    <= '0;
      float_out     <= '0;
    end else begin
      if (capture) x_q <= float_in;
      case (state_q)
        ALIGN: begin
          special_q     <= x_is_nan | x_is_inf;
          special_val_q <= x_is_nan ? C_QNAN : {~x_sign, C_EXP_MAX, {C_MANT_W{1'b0}}};
          eff_sub_q     <= ~x_sign;
          big_sign_q    <= b_bigger & ~x_sign;
          big_exp_q     <= b_bigger ? b_exp : a_exp;
          big_sig_q     <= {(b_bigger ? b_sig : a_sig), 3'b000};
          small_sig_q   <= small_aligned;
        end
        ADD: begin
          sum_q      <= eff_sub_q ? ({1'b0, big_sig_q} - {1'b0, small_sig_q})
                                  : ({1'b0, big_sig_q} + {1'b0, small_sig_q});
          res_sign_q <= big_sign_q;
          res_exp_q  <= $signed({2'b00, big_exp_q});
        end
        NORM: begin
          norm_sig_q <= norm_sig_d;
          norm_exp_q <= norm_exp_d;
        end
        ROUND:   float_out <= result_d;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_float_sub_1d5.sv
// Directed self-checking bench for float_sub_1d5 (1.5 - x) with hand-computed results.
module tb_float_sub_1d5;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] float_in;
  logic [31:0] float_out;
  logic        ready;

  int n_tests = 0;
  int n_fail  = 0;

  localparam int N_VEC = 18;
  logic [31:0] vec_x [N_VEC] = '{
    32'h3F00_0000, 32'h4000_0000, 32'hBF80_0000, 32'h3FC0_0000,
    32'h3380_0000, 32'h3400_0000, 32'h7F80_0000, 32'hFF80_0000,
    32'h7FC0_0001, 32'h0000_0000, 32'h8000_0000, 32'h3FC0_0001,
    32'h4B80_0000, 32'hBEFF_FFFF, 32'hFF7F_FFFF, 32'hC000_0000,
    32'h0000_0001, 32'hFFC0_0000
  };
  logic [31:0] vec_y [N_VEC] = '{
    32'h3F80_0000, 32'hBF00_0000, 32'h4020_0000, 32'h0000_0000,
    32'h3FC0_0000, 32'h3FBF_FFFF, 32'hFF80_0000, 32'h7F80_0000,
    32'h7FC0_0000, 32'h3FC0_0000, 32'h3FC0_0000, 32'hB400_0000,
    32'hCB7F_FFFE, 32'h4000_0000, 32'h7F7F_FFFF, 32'h4060_0000,
    32'h3FC0_0000, 32'h7FC0_0000
  };

  always #5 clk = ~clk;

  float_sub_1d5 dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .float_in  (float_in),
    .float_out (float_out),
    .ready     (ready)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, want);
    end
  endtask

  // One operation; noisy mode wiggles start/float_in while the operation is in flight.
  task automatic do_op(input string tag, input logic [31:0] x, input logic [31:0] want,
                       input bit noisy);
    int lat;
    @(negedge clk);
    float_in = x;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat   = 99;
    for (int k = 1; k <= 10; k++) begin
      if (noisy && k <= 4) begin
        start    = (k % 2 == 0);
        float_in = $urandom;
      end
      @(posedge clk); #1;
      if (ready) begin
        lat = k;
        break;
      end
    end
    start = 1'b0;
    check({tag, "_latency"}, lat, 32'd4);
    check(tag, float_out, want);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic        seen;
    logic [14:0] rdy_hist;

    rst      = 1'b1;
    start    = 1'b1;
    float_in = 32'h4000_0000;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready", {31'd0, ready}, 32'd0);
    check("reset_out", float_out, 32'd0);
    rst   = 1'b0;
    start = 1'b0;
    seen  = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      seen |= ready;
    end
    check("idle_quiet", {31'd0, seen}, 32'd0);

    for (int i = 0; i < N_VEC; i++)
      do_op($sformatf("vec%0d", i), vec_x[i], vec_y[i], (i % 3 == 1));

    // DONE holds ready and the result while start stays low.
    repeat (3) @(posedge clk);
    #1;
    check("hold_ready", {31'd0, ready}, 32'd1);
    check("hold_out", float_out, 32'h7FC0_0000);

    // start held high: results every 5 cycles, ready high one cycle in each.
    @(negedge clk);
    float_in = 32'h3F00_0000;
    start    = 1'b1;
    rdy_hist = '0;
    for (int e = 0; e < 15; e++) begin
      @(posedge clk); #1;
      rdy_hist[e] = ready;
      if (e == 4) begin
        check("b2b_op0", float_out, 32'h3F80_0000);
        float_in = 32'h4000_0000;
      end
      if (e == 9) begin
        check("b2b_op1", float_out, 32'hBF00_0000);
        float_in = 32'hBF80_0000;
      end
      if (e == 14) check("b2b_op2", float_out, 32'h4020_0000);
    end
    start = 1'b0;
    check("b2b_ready_pattern", {17'd0, rdy_hist}, 32'h0000_4210);

    // Reset while in NORM aborts the operation.
    @(negedge clk);
    float_in = 32'h3F00_0000;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_ready", {31'd0, ready}, 32'd0);
    check("abort_out", float_out, 32'd0);
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      seen |= ready;
    end
    check("abort_quiet", {31'd0, seen}, 32'd0);
    check("abort_out_held", float_out, 32'd0);
    do_op("after_abort", 32'h4000_0000, 32'hBF00_0000, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
